// File: rtl/circuit_eval_pkg.sv
// Shared types and sizing helpers for the candidate-circuit fitness evaluator.
package circuit_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic int unsigned rows_f(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Wide enough to hold a count of every row matching without wrapping.
    function automatic int unsigned fit_w_f(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

endpackage

// File: rtl/circuit_evaluator_cut_sync.sv
// Two-flop synchroniser for an asynchronous evolved-circuit output; reads 0 while in reset.
module cut_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/circuit_evaluator.sv
// Walks every input row of a candidate circuit, samples its settled output and scores it against a target.
// Optional CIRCUIT_EVAL_OSC_DETECT_EN: multi-sample per-row stability checking.
module circuit_evaluator
    import circuit_eval_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLES       = 4,
    localparam int unsigned ROWS         = rows_f(N_IN),
    localparam int unsigned FIT_W        = fit_w_f(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWS-1:0]   target,
    output logic [N_IN-1:0]   cut_inp,
    input  logic              cut_out,
    output logic              busy,
    output logic              done,
    output logic [ROWS-1:0]   match_mask,
    output logic [FIT_W-1:0]  fitness,
    output logic              unstable
);

`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
    localparam int unsigned NSAMP = SAMPLES;
`else
    localparam int unsigned NSAMP = 1;
`endif
    localparam int unsigned     CNT_W    = $clog2(SETTLE_CYCLES + SAMPLES + 1);
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROWS-1:0]       tgt_q, tgt_d;
    logic                  row_val_q, row_val_d;
    logic [N_IN-1:0]       inp_d;
    logic                  busy_d, done_d, unst_d;
    logic [ROWS-1:0]       mask_d;
    logic [FIT_W-1:0]      fit_d;
    logic                  sync_val;
    logic                  first_smp, cur_val, cur_bad, row_hit;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
    logic                  row_bad_q, row_bad_d;
`endif

    cut_sync u_cut_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cut_out),
        .sync_out (sync_val)
    );

    // Row verdict including the sample taken this cycle.
    always_comb begin
        first_smp = (cnt_q == '0);
        cur_val   = first_smp ? sync_val : row_val_q;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
        cur_bad   = !first_smp && (row_bad_q || (sync_val != row_val_q));
`else
        cur_bad   = 1'b0;
`endif
        row_hit   = !cur_bad && (cur_val == tgt_q[cut_inp]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        row_val_d = row_val_q;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
        row_bad_d = row_bad_q;
`endif
        inp_d     = cut_inp;
        busy_d    = busy;
        done_d    = 1'b0;
        mask_d    = match_mask;
        fit_d     = fitness;
        unst_d    = unstable;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    mask_d  = '0;
                    fit_d   = '0;
                    unst_d  = 1'b0;
                    inp_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                row_val_d = cur_val;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
                row_bad_d = cur_bad;
`endif
                if (cnt_q == CNT_W'(NSAMP - 1)) begin
                    // Row boundary: commit verdict, then advance or finish.
                    cnt_d           = '0;
                    mask_d[cut_inp] = row_hit;
                    if (row_hit) fit_d = fitness + FIT_W'(1);
                    if (cur_bad) unst_d = 1'b1;
                    if (cut_inp == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        inp_d   = cut_inp + N_IN'(1);
                        state_d = SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tgt_q      <= '0;
            row_val_q  <= 1'b0;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
            row_bad_q  <= 1'b0;
`endif
            cut_inp    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match_mask <= '0;
            fitness    <= '0;
            unstable   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            row_val_q  <= row_val_d;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
            row_bad_q  <= row_bad_d;
`endif
            cut_inp    <= inp_d;
            busy       <= busy_d;
            done       <= done_d;
            match_mask <= mask_d;
            fitness    <= fit_d;
            unstable   <= unst_d;
        end
    end

endmodule

// File: tb/tb_circuit_evaluator.sv
// Randomised bench for circuit_evaluator with a trace-based reference model of row sampling and scoring.
module tb_circuit_evaluator;

    localparam int S = 8;
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
    localparam int NS      = 4;
    localparam int LAT_LIT = 49;
`else
    localparam int NS      = 1;
    localparam int LAT_LIT = 37;
`endif
    localparam int ROWS   = 4;
    localparam int ROWLEN = S + NS;
    localparam int LAT    = ROWS * ROWLEN + 1;
    localparam int HN     = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic [1:0] cut_inp;
    logic       cut_out;
    logic       busy, done, unstable;
    logic [3:0] match_mask;
    logic [2:0] fitness;

    // Candidate circuit: truth table plus an optional row that oscillates every clock.
    logic [3:0] fn_tab = 4'b0111;
    logic       osc_en = 1'b0;
    logic [1:0] osc_row = 2'd2;
    logic       tog = 1'b0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit hist [HN];

    circuit_evaluator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .target     (target),
        .cut_inp    (cut_inp),
        .cut_out    (cut_out),
        .busy       (busy),
        .done       (done),
        .match_mask (match_mask),
        .fitness    (fitness),
        .unstable   (unstable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        tog <= ~tog;
    end

    assign cut_out = (osc_en && cut_inp == osc_row) ? tog : fn_tab[cut_inp];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluation timeline from the accept edge, row verdicts from the recorded CUT trace.
    bit         active = 1'b0;
    int         t0 = 0;
    logic [3:0] tgt_m = 4'd0;
    logic [3:0] h_mask = 4'd0;
    int         h_fit = 0;
    bit         h_un = 1'b0;
    int         exp_inp = 0;

    always @(negedge clk) begin
        int k, e0;
        bit eb, ed, v0, bad;
        hist[(cyc + 1) % HN] = cut_out;
        if (rst) begin
            active = 1'b0; h_mask = 4'd0; h_fit = 0; h_un = 1'b0; exp_inp = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_mask", match_mask, 0);
            chk("rst_fitness", fitness, 0);
            chk("rst_unstable", unstable, 0);
            chk("rst_cut_inp", cut_inp, 0);
        end else begin
            k  = cyc - t0;
            eb = active && (k < LAT);
            ed = active && (k == LAT);
            if (eb) exp_inp = (k / ROWLEN < ROWS) ? k / ROWLEN : ROWS - 1;
            if (ed) begin
                h_mask = 4'd0; h_fit = 0; h_un = 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    e0  = t0 + r * ROWLEN + S + 1;
                    v0  = hist[(e0 - 2) % HN];
                    bad = 1'b0;
                    for (int j = 1; j < NS; j++)
                        if (hist[(e0 + j - 2) % HN] != v0) bad = 1'b1;
                    if (bad) h_un = 1'b1;
                    else if (v0 == tgt_m[r]) begin
                        h_mask[r] = 1'b1;
                        h_fit++;
                    end
                end
            end
            chk("busy", busy, int'(eb));
            chk("done", done, int'(ed));
            chk("cut_inp", cut_inp, exp_inp);
            if (!eb) begin
                chk("match_mask", match_mask, h_mask);
                chk("fitness", fitness, h_fit);
                chk("unstable", unstable, int'(h_un));
            end
            if (ed) active = 1'b0;
            if (!eb && start) begin
                active = 1'b1;
                t0     = cyc + 1;
                tgt_m  = target;
            end
        end
    end

    task automatic start_eval(input logic [3:0] t, output int tacc);
        @(posedge clk); #1;
        target = t;
        start  = 1'b1;
        tacc   = cyc + 1;
        @(posedge clk); #1;
        start  = 1'b0;
        target = 4'($urandom);
    endtask

    task automatic wait_done(input int tacc, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cyc - tacc;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_results(input string tag, input int m, input int f, input int u);
        chk({tag, "_mask"}, match_mask, m);
        chk({tag, "_fitness"}, fitness, f);
        chk({tag, "_unstable"}, unstable, u);
    endtask

    initial begin
        int ta, lat, nchg, dcount;
        int runs [4];
        logic [1:0] prev;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_cut_inp", cut_inp, 0);
        chk("init_fitness", fitness, 0);
        rst = 1'b0;

        // NAND vs matching target, with the row-walk of cut_inp recorded.
        fn_tab = 4'b0111; osc_en = 1'b0;
        start_eval(4'b0111, ta);
        runs = '{0, 0, 0, 0};
        nchg = 0;
        prev = cut_inp;
        for (int k = 0; k < ROWS * ROWLEN; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (cut_inp != prev) nchg++;
            prev = cut_inp;
            runs[cut_inp]++;
        end
        for (int v = 0; v < ROWS; v++) chk("row_hold_len", runs[v], ROWLEN);
        chk("row_changes", nchg, 3);
        wait_done(ta, lat);
        chk("nand_latency", lat, LAT_LIT);
        chk_results("nand", 4'b1111, 4, 0);

        start_eval(4'b1000, ta);
        wait_done(ta, lat);
        chk_results("inverse", 4'b0000, 0, 0);

        // Row 2 oscillates.
        osc_en = 1'b1; osc_row = 2'd2;
        start_eval(4'b0111, ta);
        wait_done(ta, lat);
        chk("osc_latency", lat, LAT_LIT);
`ifdef CIRCUIT_EVAL_OSC_DETECT_EN
        chk_results("osc", 4'b1011, 3, 1);
`else
        chk("osc_unstable", unstable, 0);
`endif
        osc_en = 1'b0;

        // Reset 20 cycles into an evaluation.
        start_eval(4'b0111, ta);
        while (cyc < ta + 20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cut_inp", cut_inp, 0);
        chk("midrst_fitness", fitness, 0);
        @(posedge clk); #1 rst = 1'b0;
        dcount = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        start_eval(4'b0111, ta);
        wait_done(ta, lat);
        chk("after_rst_fitness", fitness, 4);

        // start held through the evaluation, released in the done cycle.
        @(posedge clk); #1;
        target = 4'b0111; start = 1'b1; ta = cyc + 1;
        wait_done(ta, lat);
        start = 1'b0;
        chk("held_latency", lat, LAT_LIT);
        @(posedge clk); #1;
        chk("held_no_restart", busy, 0);

        // start still high in the done cycle launches the next evaluation.
        @(posedge clk); #1;
        start = 1'b1; ta = cyc + 1;
        wait_done(ta, lat);
        @(posedge clk); #1;
        chk("rearm_busy", busy, 1);
        start = 1'b0;
        wait_done(cyc, lat);
        chk("rearm_latency", lat, LAT_LIT);

        // Randomised evaluations with start noise while busy.
        for (int n = 0; n < 16; n++) begin
            fn_tab  = 4'($urandom);
            osc_en  = 1'($urandom);
            osc_row = 2'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            target = 4'($urandom); start = 1'b1; ta = cyc + 1;
            for (int i = 0; i < LAT - 4; i++) begin
                @(posedge clk); #1;
                start  = 1'($urandom);
                target = 4'($urandom);
            end
            start = 1'b0;
            wait_done(ta, lat);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
